// File: rtl/mmc_cmd_control_layer_write.sv
// mmc_cmd_control_layer_write: SPI-mode MMC/SD CMD24/CMD25 block-write sequencer.
// Define MMC_WRITE_CRC16_EN to send a real CRC16 per block instead of 0xFF,0xFF.
module mmc_cmd_control_layer_write #(
    parameter int P_BUFF_DW = 32,
    parameter int P_BLOCK_BYTES = 512,
    parameter int P_RESP_POLL = 16,
    parameter int P_BUSY_POLL = 65535,
    localparam int AW = $clog2(P_BLOCK_BYTES * 8 / P_BUFF_DW)
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESET_SYNC,
    input  logic                 iCMD_START,
    input  logic                 iCMD_MULTI,
    input  logic [31:0]          iCMD_ADDR,
    input  logic [15:0]          iCMD_BLOCKS,
    output logic                 oCMD_END,
    output logic                 oCMD_ERROR,
    output logic [2:0]           oCMD_ERRCODE,
    output logic [15:0]          oBUFF_BLK,
    output logic [AW-1:0]        oBUFF_ADDR,
    input  logic [P_BUFF_DW-1:0] iBUFF_DATA,
    output logic                 oMMC_REQ,
    input  logic                 iMMC_BUSY,
    output logic                 oMMC_CS,
    output logic [7:0]           oMMC_DATA,
    input  logic                 iMMC_VALID,
    input  logic [7:0]           iMMC_DATA
);
    localparam int LANES = P_BUFF_DW / 8;
    localparam int BB = $clog2(P_BLOCK_BYTES);
    localparam logic [15:0] RESP_LIM = 16'(P_RESP_POLL);
    localparam logic [15:0] BUSY_LIM = 16'(P_BUSY_POLL);
    localparam logic [15:0] LAST_BYTE = 16'(P_BLOCK_BYTES - 1);

    typedef enum logic [4:0] {
        IDLE, CMD, RESP_REQ, RESP_GET, GAP_REQ, GAP_GET, TOKEN, DATA, CRC,
        DRESP_REQ, DRESP_GET, BUSY_REQ, BUSY_GET, STOP, DUMMY_REQ, DUMMY_GET, END
    } state_t;

    state_t state;
    logic multi, stopSent, cs, acc;
    logic [31:0] addr;
    logic [15:0] blocks, blk, cnt, poll;
    logic [2:0] errCode;
    logic [BB-1:0] byteIdx;
    logic [1:0] lane;
    logic [7:0] cmdByte, dataByte, crcByte;

    assign byteIdx = cnt[BB-1:0];
    assign lane = 2'(byteIdx % LANES);
    assign oBUFF_ADDR = AW'(byteIdx / LANES);
    assign oBUFF_BLK = blk;
    assign dataByte = 8'(iBUFF_DATA >> {lane, 3'b000});
    assign cmdByte = cnt == 16'd0 ? {7'b0101100, multi} :
                     cnt == 16'd1 ? addr[31:24] :
                     cnt == 16'd2 ? addr[23:16] :
                     cnt == 16'd3 ? addr[15:8] :
                     cnt == 16'd4 ? addr[7:0] : 8'h01;
    assign oMMC_DATA = state == CMD   ? cmdByte :
                       state == TOKEN ? (multi ? 8'hFC : 8'hFE) :
                       state == DATA  ? dataByte :
                       state == CRC   ? crcByte :
                       state == STOP  ? 8'hFD : 8'hFF;
    assign oMMC_REQ = !iMMC_BUSY && (state inside {CMD, RESP_REQ, GAP_REQ, TOKEN, DATA, CRC,
                                                   DRESP_REQ, BUSY_REQ, STOP, DUMMY_REQ});
    assign acc = oMMC_REQ;
    assign oMMC_CS = cs;

`ifdef MMC_WRITE_CRC16_EN
    logic [15:0] crc;

    function automatic logic [15:0] crcNext(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always_ff @(posedge iCLOCK or negedge inRESET)
        if (!inRESET) crc <= '0;
        else if (iRESET_SYNC || state == TOKEN) crc <= '0;
        else if (state == DATA && acc) crc <= crcNext(crc, dataByte);

    assign crcByte = cnt[0] ? crc[7:0] : crc[15:8];
`else
    assign crcByte = 8'hFF;
`endif

    // Data-phase failures of a multi-block write must still close the stream with a stop token.
    function automatic state_t errState(input logic [2:0] code);
        return (multi && !stopSent && code >= 3'd3) ? STOP : DUMMY_REQ;
    endfunction

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE; multi <= 1'b0; addr <= '0; blocks <= '0; blk <= '0;
            cnt <= '0; poll <= '0; stopSent <= 1'b0; errCode <= '0; cs <= 1'b1;
            oCMD_END <= 1'b0; oCMD_ERROR <= 1'b0; oCMD_ERRCODE <= '0;
        end else if (iRESET_SYNC) begin
            state <= IDLE; multi <= 1'b0; addr <= '0; blocks <= '0; blk <= '0;
            cnt <= '0; poll <= '0; stopSent <= 1'b0; errCode <= '0; cs <= 1'b1;
            oCMD_END <= 1'b0; oCMD_ERROR <= 1'b0; oCMD_ERRCODE <= '0;
        end else begin
            oCMD_END <= 1'b0;
            case (state)
                IDLE: if (iCMD_START) begin
                    multi <= iCMD_MULTI;
                    addr <= iCMD_ADDR;
                    blocks <= iCMD_BLOCKS == 16'd0 ? 16'd1 : iCMD_BLOCKS;
                    blk <= '0; cnt <= '0; poll <= '0; stopSent <= 1'b0; errCode <= '0;
                    oCMD_ERROR <= 1'b0; oCMD_ERRCODE <= '0; cs <= 1'b0;
                    state <= CMD;
                end
                CMD: if (acc) begin
                    cnt <= cnt == 16'd5 ? 16'd0 : cnt + 16'd1;
                    state <= cnt == 16'd5 ? RESP_REQ : CMD;
                end
                RESP_REQ: if (acc) begin
                    poll <= poll == 16'hFFFF ? poll : poll + 16'd1;
                    state <= RESP_GET;
                end
                RESP_GET: if (iMMC_VALID) begin
                    if (iMMC_DATA == 8'h00) state <= GAP_REQ;
                    else if (iMMC_DATA != 8'hFF) begin errCode <= 3'd2; state <= DUMMY_REQ; end
                    else if (poll >= RESP_LIM) begin errCode <= 3'd1; state <= DUMMY_REQ; end
                    else state <= RESP_REQ;
                end
                GAP_REQ: if (acc) state <= GAP_GET;
                GAP_GET: if (iMMC_VALID) begin
                    poll <= '0;
                    state <= stopSent ? BUSY_REQ : TOKEN;
                end
                TOKEN: if (acc) begin
                    cnt <= '0;
                    state <= DATA;
                end
                DATA: if (acc) begin
                    cnt <= cnt == LAST_BYTE ? 16'd0 : cnt + 16'd1;
                    state <= cnt == LAST_BYTE ? CRC : DATA;
                end
                CRC: if (acc) begin
                    cnt <= cnt == 16'd1 ? 16'd0 : cnt + 16'd1;
                    state <= cnt == 16'd1 ? DRESP_REQ : CRC;
                end
                DRESP_REQ: if (acc) state <= DRESP_GET;
                DRESP_GET: if (iMMC_VALID) begin
                    poll <= '0;
                    if (iMMC_DATA[4:0] == 5'h05) state <= BUSY_REQ;
                    else if (iMMC_DATA[4:0] == 5'h0B) begin errCode <= 3'd3; state <= errState(3'd3); end
                    else if (iMMC_DATA[4:0] == 5'h0D) begin errCode <= 3'd4; state <= errState(3'd4); end
                    else state <= DRESP_REQ;
                end
                BUSY_REQ: if (acc) begin
                    poll <= poll == 16'hFFFF ? poll : poll + 16'd1;
                    state <= BUSY_GET;
                end
                BUSY_GET: if (iMMC_VALID) begin
                    if (iMMC_DATA[0]) begin
                        if (stopSent || !multi) state <= DUMMY_REQ;
                        else if (blk != blocks - 16'd1) begin blk <= blk + 16'd1; state <= GAP_REQ; end
                        else state <= STOP;
                    end
                    else if (poll >= BUSY_LIM) begin errCode <= 3'd5; state <= errState(3'd5); end
                    else state <= BUSY_REQ;
                end
                STOP: if (acc) begin
                    stopSent <= 1'b1;
                    state <= errCode != 3'd0 ? DUMMY_REQ : GAP_REQ;
                end
                DUMMY_REQ: if (acc) state <= DUMMY_GET;
                DUMMY_GET: if (iMMC_VALID) begin
                    oCMD_END <= 1'b1;
                    oCMD_ERROR <= errCode != 3'd0;
                    oCMD_ERRCODE <= errCode;
                    cs <= 1'b1;
                    state <= END;
                end
                END: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmc_cmd_control_layer_write.sv
// tb_mmc_cmd_control_layer_write: directed vectors against a scripted SPI engine and card model.
module tb_mmc_cmd_control_layer_write;
    logic iCLOCK = 1'b0, inRESET = 1'b0, iRESET_SYNC = 1'b0;
    logic iCMD_START = 1'b0, iCMD_MULTI = 1'b0;
    logic [31:0] iCMD_ADDR = '0;
    logic [15:0] iCMD_BLOCKS = '0;
    logic oCMD_END, oCMD_ERROR, oMMC_REQ, oMMC_CS;
    logic [2:0] oCMD_ERRCODE;
    logic [15:0] oBUFF_BLK;
    logic [6:0] oBUFF_ADDR;
    logic [31:0] iBUFF_DATA;
    logic iMMC_BUSY = 1'b0, iMMC_VALID = 1'b0;
    logic [7:0] oMMC_DATA, iMMC_DATA = 8'hFF;

    mmc_cmd_control_layer_write dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iCMD_START(iCMD_START), .iCMD_MULTI(iCMD_MULTI), .iCMD_ADDR(iCMD_ADDR),
        .iCMD_BLOCKS(iCMD_BLOCKS), .oCMD_END(oCMD_END), .oCMD_ERROR(oCMD_ERROR),
        .oCMD_ERRCODE(oCMD_ERRCODE), .oBUFF_BLK(oBUFF_BLK), .oBUFF_ADDR(oBUFF_ADDR),
        .iBUFF_DATA(iBUFF_DATA), .oMMC_REQ(oMMC_REQ), .iMMC_BUSY(iMMC_BUSY),
        .oMMC_CS(oMMC_CS), .oMMC_DATA(oMMC_DATA), .iMMC_VALID(iMMC_VALID), .iMMC_DATA(iMMC_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    int checks = 0, failures = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endfunction

    // Buffer contents encode block and word index so misaddressing shows up as wrong data.
    logic ffMode = 1'b0;
    assign iBUFF_DATA = ffMode ? 32'hFFFF_FFFF :
        {oBUFF_BLK[7:0] + 8'h30, 1'b0, oBUFF_ADDR, oBUFF_BLK[7:0], 1'b1, oBUFF_ADDR};

    function automatic logic [7:0] expByte(input int b, input int n);
        int w;
        w = n / 4;
        if (ffMode) return 8'hFF;
        case (n % 4)
            0: return {1'b1, 7'(w)};
            1: return 8'(b);
            2: return {1'b0, 7'(w)};
            default: return 8'(b + 'h30);
        endcase
    endfunction

    localparam int PC = 0, PR1 = 1, PW = 2, PD = 3, PDR = 4, PB = 5, PSG = 6, PX = 7;
    int ph, cnt, tokens, fds, mism, r1Wait, busyBytes;
    logic [7:0] r1Val, dresp, reply, engTx;
    logic [7:0] cmdB [6];
    logic [7:0] crcB [2];
    logic engAcc;

    task automatic respond(input logic [7:0] tx, output logic [7:0] rep);
        rep = 8'hFF;
        case (ph)
            PC: begin cmdB[cnt] = tx; cnt++; if (cnt == 6) begin ph = PR1; cnt = 0; end end
            PR1: begin
                rep = cnt < r1Wait ? 8'hFF : r1Val;
                cnt++;
                if (rep != 8'hFF) ph = rep == 8'h00 ? PW : PX;
            end
            PW: if (tx == 8'hFE || tx == 8'hFC) begin tokens++; ph = PD; cnt = 0; end
                else if (tx == 8'hFD) begin fds++; ph = PSG; end
            PD: begin
                if (cnt < 512) begin if (tx !== expByte(tokens - 1, cnt)) mism++; end
                else crcB[cnt - 512] = tx;
                cnt++;
                if (cnt == 514) ph = PDR;
            end
            PDR: begin rep = dresp; ph = dresp[4:0] == 5'h05 ? PB : PW; cnt = 0; end
            PB: begin rep = cnt < busyBytes ? 8'h00 : 8'hFF; cnt++; if (rep == 8'hFF) ph = PW; end
            PSG: begin ph = PB; cnt = 0; end
            default: ;
        endcase
    endtask

    // SPI engine: each accepted byte is busy for three cycles, the reply is valid in the last one.
    initial forever begin
        @(negedge iCLOCK);
        engAcc = oMMC_REQ;
        engTx = oMMC_DATA;
        @(posedge iCLOCK); #1;
        if (engAcc) begin
            respond(engTx, reply);
            iMMC_BUSY = 1'b1;
            repeat (2) begin @(posedge iCLOCK); #1; end
            iMMC_VALID = 1'b1; iMMC_DATA = reply;
            @(posedge iCLOCK); #1;
            iMMC_VALID = 1'b0; iMMC_DATA = 8'hFF; iMMC_BUSY = 1'b0;
        end
    end

    typedef struct {
        logic multi; logic [15:0] blocks; logic [31:0] addr; int r1Wait;
        logic [7:0] r1Val; logic [7:0] dresp; int busyBytes; logic err; logic [2:0] code;
    } vec_t;
    vec_t vecs [8];

    task automatic startCmd(input vec_t v);
        ph = PC; cnt = 0; tokens = 0; fds = 0; mism = 0;
        r1Wait = v.r1Wait; r1Val = v.r1Val; dresp = v.dresp; busyBytes = v.busyBytes;
        @(posedge iCLOCK); #1;
        iCMD_START = 1'b1; iCMD_MULTI = v.multi; iCMD_ADDR = v.addr; iCMD_BLOCKS = v.blocks;
        @(posedge iCLOCK); #1;
        iCMD_START = 1'b0;
    endtask

    task automatic runVec(input vec_t v, input int id);
        bit got;
        int nb, expTok, expFd;
        nb = v.blocks == 16'd0 ? 1 : int'(v.blocks);
        expTok = !v.err ? (v.multi ? nb : 1) : (v.code >= 3'd3 ? 1 : 0);
        expFd = (v.multi && (!v.err || v.code >= 3'd3)) ? 1 : 0;
        startCmd(v);
        @(negedge iCLOCK);
        check($sformatf("v%0d cs_selected", id), 32'(oMMC_CS), 32'd0);
        got = 0;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(negedge iCLOCK);
            if (oCMD_END) got = 1;
        end
        check($sformatf("v%0d end_seen", id), 32'(got), 32'd1);
        check($sformatf("v%0d error", id), 32'(oCMD_ERROR), 32'(v.err));
        check($sformatf("v%0d errcode", id), 32'(oCMD_ERRCODE), 32'(v.code));
        check($sformatf("v%0d cmd_index", id), 32'(cmdB[0]), v.multi ? 32'h59 : 32'h58);
        check($sformatf("v%0d cmd_addr", id), {cmdB[1], cmdB[2], cmdB[3], cmdB[4]}, v.addr);
        check($sformatf("v%0d cmd_crc", id), 32'(cmdB[5]), 32'h01);
        check($sformatf("v%0d tokens", id), 32'(tokens), 32'(expTok));
        check($sformatf("v%0d stop_tokens", id), 32'(fds), 32'(expFd));
        check($sformatf("v%0d data_mismatch", id), 32'(mism), 32'd0);
        @(negedge iCLOCK);
        check($sformatf("v%0d end_one_cycle", id), 32'(oCMD_END), 32'd0);
        check($sformatf("v%0d error_held", id), {29'd0, oCMD_ERROR, oCMD_ERRCODE[1:0]},
              {29'd0, v.err, v.code[1:0]});
        check($sformatf("v%0d cs_released", id), 32'(oMMC_CS), 32'd1);
    endtask

    initial begin
        int endCnt;
        bit hit;
        vecs[0] = '{1'b0, 16'd1, 32'h0000_1200, 2, 8'h00, 8'hE5, 3, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 16'd3, 32'h00AB_CDEF, 0, 8'h00, 8'hE5, 2, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 16'd1, 32'h0000_0400, 16, 8'h00, 8'hE5, 1, 1'b1, 3'd1};
        vecs[3] = '{1'b0, 16'd1, 32'h1234_5678, 15, 8'h00, 8'hE5, 1, 1'b0, 3'd0};
        vecs[4] = '{1'b0, 16'd1, 32'h0000_0200, 1, 8'h04, 8'hE5, 1, 1'b1, 3'd2};
        vecs[5] = '{1'b0, 16'd1, 32'h0000_0600, 0, 8'h00, 8'hEB, 1, 1'b1, 3'd3};
        vecs[6] = '{1'b1, 16'd2, 32'h0000_0800, 0, 8'h00, 8'hED, 1, 1'b1, 3'd4};
        vecs[7] = '{1'b1, 16'd0, 32'hFFFF_FE00, 0, 8'h00, 8'hE5, 0, 1'b0, 3'd0};

        repeat (3) @(posedge iCLOCK);
        @(negedge iCLOCK);
        check("rst cs", 32'(oMMC_CS), 32'd1);
        check("rst req", 32'(oMMC_REQ), 32'd0);
        check("rst data", 32'(oMMC_DATA), 32'hFF);
        check("rst end_err", {30'd0, oCMD_END, oCMD_ERROR}, 32'd0);
        check("rst errcode", 32'(oCMD_ERRCODE), 32'd0);
        check("rst counters", {oBUFF_BLK, 9'd0, oBUFF_ADDR}, 32'd0);
        @(posedge iCLOCK); #1;
        inRESET = 1'b1;

        for (int i = 0; i < 8; i++) runVec(vecs[i], i);

        ffMode = 1'b1;
        runVec(vecs[0], 8);
`ifdef MMC_WRITE_CRC16_EN
        check("crc_all_ff", {crcB[0], crcB[1]}, 32'h7FA1);
`else
        check("crc_all_ff", {crcB[0], crcB[1]}, 32'hFFFF);
`endif
        ffMode = 1'b0;

        startCmd(vecs[0]);
        hit = 0;
        for (int c = 0; c < 5000 && !hit; c++) begin
            @(negedge iCLOCK);
            if (ph == PD && cnt >= 100) hit = 1;
        end
        check("sync data100 reached", 32'(hit), 32'd1);
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b1;
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0;
        @(negedge iCLOCK);
        check("sync cs", 32'(oMMC_CS), 32'd1);
        check("sync req", 32'(oMMC_REQ), 32'd0);
        check("sync addr", 32'(oBUFF_ADDR), 32'd0);
        endCnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge iCLOCK);
            if (oCMD_END) endCnt++;
            if (oMMC_REQ) endCnt += 100;
        end
        check("sync no_end_no_req", 32'(endCnt), 32'd0);
        runVec(vecs[0], 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
